// File: rtl/fetch_queue_unit_pkg.sv
// Shared definitions for the instruction-fetch queue unit: state encoding and parameter defaults.
package fetch_pkg;

  localparam int unsigned WIDTH_DEFAULT    = 16;
  localparam int unsigned DEPTH_DEFAULT    = 4;
  localparam int unsigned RESET_PC_DEFAULT = 0;
  localparam int unsigned PC_INC_DEFAULT   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Bundles the instruction-memory, redirect/halt control and decode-side handshake of the fetch unit.
interface fetch_queue_unit_if #(
  parameter int unsigned WIDTH = fetch_pkg::WIDTH_DEFAULT
);

  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [WIDTH-1:0] imem_rdata;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  logic             halt;
  logic             out_valid;
  logic [WIDTH-1:0] out_instr;
  logic [WIDTH-1:0] out_pc;
  logic [WIDTH-1:0] out_pc_plus;
  logic             out_ready;
  logic             q_full;
  logic             q_empty;
  logic             err;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus,
           q_full, q_empty, err,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc,
           halt, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus,
           q_full, q_empty, err,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc,
           halt, out_ready
  );

endinterface

// File: rtl/fetch_queue_unit_fifo.sv
// DEPTH-entry synchronous FIFO holding {pc, instr} pairs; flush empties it in one cycle.
module fetch_fifo #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [DW-1:0]            i_wdata,
  output logic [DW-1:0]            o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  import fetch_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage: owns the PC, issues one imem request at a time and buffers responses for decode.
module fetch_queue_unit #(
  parameter int unsigned WIDTH    = fetch_pkg::WIDTH_DEFAULT,
  parameter int unsigned DEPTH    = fetch_pkg::DEPTH_DEFAULT,
  parameter int unsigned RESET_PC = fetch_pkg::RESET_PC_DEFAULT,
  parameter int unsigned PC_INC   = fetch_pkg::PC_INC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  fetch_queue_unit_if.master bus
);
  import fetch_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = 2 * WIDTH;

  fetch_state_e     r_state;
  logic [WIDTH-1:0] r_fetch_pc;
  logic [WIDTH-1:0] r_req_pc;
  logic             r_err;

  logic             w_can_issue;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_err_evt;
  logic [CW-1:0]    w_count;
  logic [DW-1:0]    w_head;

  // Only IDLE issues, so nothing is outstanding there and count alone bounds the issue.
  assign w_can_issue = !rst && (r_state == ST_IDLE) && !bus.halt && (w_count < CW'(DEPTH));
  assign bus.imem_req  = w_can_issue || (r_state == ST_REQ);
  assign bus.imem_addr = r_fetch_pc;

  assign w_push = (r_state == ST_WAIT) && bus.imem_rvalid && !bus.redirect_valid;
  assign w_pop  = bus.out_valid && bus.out_ready;

  assign w_err_evt = (bus.imem_rvalid && ((r_state == ST_IDLE) || (r_state == ST_REQ)))
                   || (bus.imem_gnt && !bus.imem_req)
                   || (w_push && w_full);

  fetch_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.redirect_valid),
    .i_wdata ({r_req_pc, bus.imem_rdata}),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.out_valid   = !w_empty && !bus.redirect_valid;
  assign bus.out_pc      = w_head[DW-1:WIDTH];
  assign bus.out_instr   = w_head[WIDTH-1:0];
  assign bus.out_pc_plus = w_head[DW-1:WIDTH] + WIDTH'(PC_INC);
  assign bus.q_full      = w_full;
  assign bus.q_empty     = w_empty;
  assign bus.err         = r_err;

  // Redirect wins; a response that arrives with it (or after it, in DROP) is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= WIDTH'(RESET_PC);
      r_req_pc   <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_err_evt) r_err <= 1'b1;
      if (bus.redirect_valid) begin
        r_fetch_pc <= bus.redirect_pc;
        case (r_state)
          ST_REQ:  r_state <= bus.imem_gnt ? ST_DROP : ST_IDLE;
          ST_WAIT: r_state <= bus.imem_rvalid ? ST_IDLE : ST_DROP;
          ST_DROP: r_state <= bus.imem_rvalid ? ST_IDLE : ST_DROP;
          default: r_state <= ST_IDLE;
        endcase
      end else begin
        case (r_state)
          ST_IDLE: if (w_can_issue) r_state <= ST_REQ;
          ST_REQ: begin
            if (bus.imem_gnt) begin
              r_req_pc   <= r_fetch_pc;
              r_fetch_pc <= r_fetch_pc + WIDTH'(PC_INC);
              r_state    <= ST_WAIT;
            end
          end
          ST_WAIT: if (bus.imem_rvalid) r_state <= ST_IDLE;
          ST_DROP: if (bus.imem_rvalid) r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(w_push && w_full));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: transaction-level model of PC/queue/outstanding request plus directed pins.
module tb_fetch_queue_unit;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } entry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_unit_if #(.WIDTH(WIDTH)) bus ();

  fetch_queue_unit #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .RESET_PC (0),
    .PC_INC   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model: queued entries, next fetch address, and the single memory transaction's status.
  entry_t      m_q[$];
  logic [15:0] m_fetch_pc;
  logic [15:0] m_inflight_pc;
  bit          m_held;      // request raised in an earlier cycle, still waiting for grant
  bit          m_inflight;  // granted, response pending
  bit          m_stale;     // pending response must be thrown away
  bit          m_err;
  bit          e_req;
  bit          e_valid;

  bit          d_halt, d_ready, d_redir, f_gnt, f_rv;
  logic [15:0] d_rpc;
  int unsigned p_gnt, p_rv;
  bit          s_gnt, s_rv;
  logic [15:0] s_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic compare();
    logic [15:0] plus;
    e_req   = m_held || (!m_inflight && !d_halt && (m_q.size() < DEPTH));
    e_valid = (m_q.size() != 0) && !d_redir;
    chk("imem_req", bus.imem_req, e_req);
    if (e_req) chk("imem_addr", bus.imem_addr, m_fetch_pc);
    chk("out_valid", bus.out_valid, e_valid);
    if (e_valid) begin
      plus = m_q[0].pc + 16'd2;
      chk("out_instr", bus.out_instr, m_q[0].instr);
      chk("out_pc", bus.out_pc, m_q[0].pc);
      chk("out_pc_plus", bus.out_pc_plus, plus);
    end
    chk("q_full", bus.q_full, m_q.size() == DEPTH);
    chk("q_empty", bus.q_empty, m_q.size() == 0);
    chk("err", bus.err, m_err);
  endtask

  task automatic update();
    if ((s_rv && !m_inflight) || (s_gnt && !e_req)) m_err = 1'b1;
    if (d_redir) begin
      m_q.delete();
      m_fetch_pc = d_rpc;
      if (m_held) begin
        if (s_gnt) begin
          m_inflight = 1'b1;
          m_stale    = 1'b1;
        end
        m_held = 1'b0;
      end else if (m_inflight) begin
        if (s_rv) m_inflight = 1'b0;
        else      m_stale    = 1'b1;
      end
    end else begin
      if (e_valid && d_ready) void'(m_q.pop_front());
      if (m_inflight && s_rv) begin
        if (!m_stale) m_q.push_back({m_inflight_pc, s_rdata});
        m_inflight = 1'b0;
      end else if (m_held && s_gnt) begin
        m_inflight    = 1'b1;
        m_stale       = 1'b0;
        m_inflight_pc = m_fetch_pc;
        m_fetch_pc    = m_fetch_pc + 16'd2;
        m_held        = 1'b0;
      end else if (e_req && !m_held) begin
        m_held = 1'b1;
      end
    end
  endtask

  // One clock: drive inputs, check against the model, advance the model, settle after the edge.
  task automatic cycle();
    bus.halt           = d_halt;
    bus.out_ready      = d_ready;
    bus.redirect_valid = d_redir;
    bus.redirect_pc    = d_rpc;
    s_gnt   = f_gnt || (m_held && ($urandom_range(99) < p_gnt));
    s_rv    = f_rv || (m_inflight && ($urandom_range(99) < p_rv));
    s_rdata = m_inflight ? mem_word(m_inflight_pc) : 16'($urandom);
    bus.imem_gnt    = s_gnt;
    bus.imem_rvalid = s_rv;
    bus.imem_rdata  = s_rdata;
    #1;
    compare();
    update();
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    d_redir = 1'b0;
    f_gnt   = 1'b0;
    f_rv    = 1'b0;
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    d_halt = 1'b0; d_ready = 1'b0; d_redir = 1'b0; f_gnt = 1'b0; f_rv = 1'b0;
    d_rpc = 16'h0000; p_gnt = 100; p_rv = 100;
    bus.halt = 1'b0; bus.out_ready = 1'b0; bus.redirect_valid = 1'b0;
    bus.redirect_pc = 16'h0000; bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0;
    bus.imem_rdata = 16'h0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_imem_req", bus.imem_req, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_q_empty", bus.q_empty, 1);
    chk("rst_q_full", bus.q_full, 0);
    chk("rst_err", bus.err, 0);
    rst = 1'b0;
    #1;
    m_q.delete();
    m_fetch_pc = 16'h0000; m_inflight_pc = 16'h0000;
    m_held = 1'b0; m_inflight = 1'b0; m_stale = 1'b0; m_err = 1'b0;
    cyc = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;

    // Free run: first instruction three cycles after reset, then sequential PCs.
    do_reset();
    d_ready = 1'b1;
    n = 0;
    while (!bus.out_valid && n < 10) begin cycle(); n++; end
    chk("t1_first_valid_latency", n, 3);
    for (int k = 0; k < 3; k++) begin
      int w = 0;
      while (!bus.out_valid && w < 10) begin cycle(); w++; end
      chk("t1_out_pc", bus.out_pc, k * 2);
      chk("t1_out_instr", bus.out_instr, mem_word(16'(k * 2)));
      cycle();
    end

    // Back-pressure: four responses fill the queue, one pop releases exactly one request.
    do_reset();
    repeat (16) cycle();
    chk("t2_full", bus.q_full, 1);
    chk("t2_no_req_full", bus.imem_req, 0);
    d_ready = 1'b1;
    cycle();
    d_ready = 1'b0;
    chk("t2_not_full_after_pop", bus.q_full, 0);
    chk("t2_req_after_pop", bus.imem_req, 1);
    chk("t2_addr_after_pop", bus.imem_addr, 16'h0008);
    repeat (6) cycle();
    chk("t2_full_again", bus.q_full, 1);
    chk("t2_single_req", bus.imem_req, 0);

    // Redirect while waiting with two queued entries; the late response is dropped.
    do_reset();
    repeat (8) cycle();
    chk("t3_two_queued", bus.q_empty, 0);
    d_redir = 1'b1; d_rpc = 16'h0100; p_rv = 0;
    cycle();
    chk("t3_flushed", bus.q_empty, 1);
    chk("t3_drop_no_req", bus.imem_req, 0);
    p_rv = 100;
    cycle();
    chk("t3_late_rvalid_dropped", bus.q_empty, 1);
    chk("t3_req_new_pc", bus.imem_req, 1);
    chk("t3_addr_new_pc", bus.imem_addr, 16'h0100);
    d_ready = 1'b1;
    n = 0;
    while (!bus.out_valid && n < 20) begin cycle(); n++; end
    chk("t3_first_out_pc", bus.out_pc, 16'h0100);

    // Redirect coinciding with a pop and a response.
    do_reset();
    repeat (5) cycle();
    chk("t4_head_valid", bus.out_valid, 1);
    d_ready = 1'b1; d_redir = 1'b1; d_rpc = 16'h0200;
    cycle();
    chk("t4_no_push", bus.q_empty, 1);
    chk("t4_no_err", bus.err, 0);
    chk("t4_req_addr", bus.imem_addr, 16'h0200);

    // Halt with a request outstanding: it completes, then fetch stops until halt drops.
    do_reset();
    d_ready = 1'b1;
    cycle();
    d_halt = 1'b1;
    cycle();
    cycle();
    chk("t5_queued", bus.out_valid, 1);
    chk("t5_queued_pc", bus.out_pc, 16'h0000);
    seen = 0;
    repeat (10) begin cycle(); if (bus.imem_req) seen++; end
    chk("t5_no_req_halted", seen, 0);
    d_halt = 1'b0;
    bus.halt = 1'b0;
    #1;
    chk("t5_resume_req", bus.imem_req, 1);
    chk("t5_resume_addr", bus.imem_addr, 16'h0002);

    // PC wrap at 0xFFFE, then an unsolicited response sets the sticky error.
    do_reset();
    d_ready = 1'b1; d_redir = 1'b1; d_rpc = 16'hFFFE;
    cycle();
    chk("t6_req_addr", bus.imem_addr, 16'hFFFE);
    repeat (3) cycle();
    chk("t6_wrap_addr", bus.imem_addr, 16'h0000);
    chk("t6_head_valid", bus.out_valid, 1);
    chk("t6_head_pc", bus.out_pc, 16'hFFFE);
    chk("t6_pc_plus_wrap", bus.out_pc_plus, 16'h0000);
    d_halt = 1'b1;
    repeat (3) cycle();
    f_rv = 1'b1;
    cycle();
    chk("t6_err_set", bus.err, 1);
    repeat (5) cycle();
    chk("t6_err_sticky", bus.err, 1);

    // Randomised traffic against the model.
    do_reset();
    p_gnt = 60; p_rv = 50;
    repeat (3000) begin
      d_halt  = ($urandom_range(99) < 10);
      d_ready = ($urandom_range(99) < 60);
      d_redir = ($urandom_range(99) < 3);
      d_rpc   = 16'($urandom) & 16'hFFFE;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
